// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit storage register among N requesters.
// An owner may lock the register for back-to-back writes, for at most MAX_HOLD grants in a row.
module reg_share_arbiter #(
    parameter int N        = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           req,
    input  logic [N-1:0]           lock,
    input  logic [N*WIDTH-1:0]     wdata,
    output logic [N-1:0]           gnt,
    output logic [WIDTH-1:0]       Q,
    output logic                   wr_en,
    output logic [$clog2(N)-1:0]   owner
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [HW-1:0]   hold_cnt;

    logic            win_valid;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   ptr_next;
    logic [HW-1:0]   hold_next;
    logic            lock_next;
    logic [N-1:0]    gnt_next;
    int              scan_idx;

    // A live lock keeps the owner; otherwise scan from ptr with wrap-around.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        if (state == LOCKED && req[owner] && int'(hold_cnt) < MAX_HOLD) begin
            win_valid = 1'b1;
            win_idx   = owner;
        end else begin
            for (int i = 0; i < N; i++) begin
                scan_idx = int'(ptr) + i;
                if (scan_idx >= N)
                    scan_idx = scan_idx - N;
                if (!win_valid && req[scan_idx]) begin
                    win_valid = 1'b1;
                    win_idx   = IW'(scan_idx);
                end
            end
        end

        ptr_next  = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
        hold_next = (state == LOCKED && win_idx == owner) ? hold_cnt + HW'(1) : HW'(1);
        // Reaching the hold limit wins over a lock request on the same edge.
        lock_next = lock[win_idx] && (int'(hold_next) < MAX_HOLD);

        gnt_next = '0;
        if (win_valid)
            gnt_next[win_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            Q        <= '0;
            wr_en    <= 1'b0;
            owner    <= '0;
        end else if (win_valid) begin
            Q        <= wdata[int'(win_idx)*WIDTH +: WIDTH];
            gnt      <= gnt_next;
            wr_en    <= 1'b1;
            owner    <= win_idx;
            ptr      <= ptr_next;
            hold_cnt <= hold_next;
            state    <= lock_next ? LOCKED : GRANT;
        end else begin
            gnt      <= '0;
            wr_en    <= 1'b0;
            hold_cnt <= '0;
            state    <= IDLE;
        end
    end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter: stimulus pushes hand-computed expectations,
// a monitor pops and compares them one cycle later.
module tb_reg_share_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  Q;
    logic        wr_en;
    logic [1:0]  owner;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] q;
        logic       wr_en;
        logic [1:0] owner;
        string      name;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;

    reg_share_arbiter #(.N(4), .WIDTH(8), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .lock  (lock),
        .wdata (wdata),
        .gnt   (gnt),
        .Q     (Q),
        .wr_en (wr_en),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input exp_t e);
        checks++;
        if (gnt !== e.gnt || Q !== e.q || wr_en !== e.wr_en || owner !== e.owner) begin
            errors++;
            $display("[TB] FAIL %s: got gnt=%b Q=%h wr_en=%b owner=%0d, want gnt=%b Q=%h wr_en=%b owner=%0d",
                     e.name, gnt, Q, wr_en, owner, e.gnt, e.q, e.wr_en, e.owner);
        end
    endtask

    // Drive at a falling edge, queue the response expected after the next rising edge.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l, input logic [31:0] wd,
                                 input logic [3:0] eg, input logic [7:0] eq, input logic ew,
                                 input logic [1:0] eo, input string nm);
        exp_t e;
        req   = r;
        lock  = l;
        wdata = wd;
        e.gnt = eg; e.q = eq; e.wr_en = ew; e.owner = eo; e.name = nm;
        expq.push_back(e);
        @(negedge clk);
    endtask

    task automatic doReset();
        req   = '0;
        lock  = '0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        exp_t r;
        logic [31:0] wd;
        logic [1:0]  seq_owner [10];
        r.gnt = '0; r.q = '0; r.wr_en = 1'b0; r.owner = '0;

        // Reset and single request
        reset = 1'b1;
        req   = 4'b0010;
        lock  = '0;
        wdata = 32'h0000_A500;
        #2;
        r.name = "reset_initial";
        checkOutput(r);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(4'b0010, 4'b0000, 32'h0000_A500, 4'b0010, 8'hA5, 1'b1, 2'd1, "single_req");
        applyStimulus(4'b0000, 4'b0000, 32'h0000_5A00, 4'b0000, 8'hA5, 1'b0, 2'd1, "single_idle");

        // Round robin, all requesting
        doReset();
        wd = 32'h1312_1110;
        for (int i = 0; i < 8; i++)
            applyStimulus(4'b1111, 4'b0000, wd, 4'b0001 << (i % 4), 8'h10 + 8'(i % 4),
                          1'b1, 2'(i % 4), $sformatf("rr_%0d", i));

        // Lock with forced rotation
        doReset();
        wd = 32'h2322_2120;
        seq_owner = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
        for (int i = 0; i < 10; i++)
            applyStimulus(4'b0101, 4'b0001, wd, 4'b0001 << seq_owner[i], 8'h20 + 8'(seq_owner[i]),
                          1'b1, seq_owner[i], $sformatf("forced_rot_%0d", i));

        // Sole locked requester wins again after the hold limit
        doReset();
        for (int i = 0; i < 5; i++)
            applyStimulus(4'b0001, 4'b0001, 32'h0000_0077, 4'b0001, 8'h77, 1'b1, 2'd0,
                          $sformatf("sole_lock_%0d", i));

        // Early lock release, then a fresh hold sequence
        doReset();
        wd = 32'h3332_3130;
        seq_owner = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
        for (int i = 0; i < 10; i++)
            applyStimulus(4'b1111, (i == 0 || i >= 5) ? 4'b0001 : 4'b0000, wd,
                          4'b0001 << seq_owner[i], 8'h30 + 8'(seq_owner[i]), 1'b1, seq_owner[i],
                          $sformatf("early_rel_%0d", i));

        // Wrap and skip
        doReset();
        wd = 32'h4342_4140;
        applyStimulus(4'b0100, 4'b0000, wd, 4'b0100, 8'h42, 1'b1, 2'd2, "wrap_r2");
        applyStimulus(4'b0011, 4'b0000, wd, 4'b0001, 8'h40, 1'b1, 2'd0, "wrap_r0");
        applyStimulus(4'b0011, 4'b0000, wd, 4'b0010, 8'h41, 1'b1, 2'd1, "wrap_r1");
        applyStimulus(4'b1000, 4'b0000, wd, 4'b1000, 8'h43, 1'b1, 2'd3, "wrap_r3");
        applyStimulus(4'b1001, 4'b0000, wd, 4'b0001, 8'h40, 1'b1, 2'd0, "wrap_to_0");

        // Asynchronous reset in the middle of a lock
        doReset();
        wd = 32'h5352_5150;
        applyStimulus(4'b0010, 4'b0010, wd, 4'b0010, 8'h51, 1'b1, 2'd1, "midlock_1");
        applyStimulus(4'b0010, 4'b0010, wd, 4'b0010, 8'h51, 1'b1, 2'd1, "midlock_2");
        #2;
        reset = 1'b1;
        #1;
        r.name = "async_reset";
        checkOutput(r);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(4'b1000, 4'b0000, wd, 4'b1000, 8'h53, 1'b1, 2'd3, "after_reset");
        applyStimulus(4'b0000, 4'b0000, wd, 4'b0000, 8'h53, 1'b0, 2'd3, "final_idle");

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
